// File: rtl/uart_tx_pkg.sv
// Shared UART transmit definitions: FSM state encoding and serial line levels.
package uart_tx_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Parity generator for the UART frame: even parity by default, odd when typ=1.
module uart_parity_calc #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  typ,
  output logic                  parity_c
);

  assign parity_c = (^data) ^ typ;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start, DATA_WIDTH data bits from an external
// serializer, optional parity (macro UART_TX_PARITY_EN), stop. One bit per CLK.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
`ifdef UART_TX_PARITY_EN
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
`endif
  output logic [DATA_WIDTH-1:0] ser_p_data,
  output logic                  ser_en,
  input  logic                  ser_data,
  input  logic                  ser_done,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  tx_state_e state_q;
  tx_state_e state_d;
  logic      accept;

  assign accept = (state_q == IDLE) && DATA_VALID;

  // State register; reset aborts any frame in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame data is captured once per request and held until the next accept.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ser_p_data <= '0;
    end else if (accept) begin
      ser_p_data <= P_DATA;
    end
  end

`ifdef UART_TX_PARITY_EN
  logic par_en_q;
  logic par_typ_q;
  logic parity_bit;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
    end else if (accept) begin
      par_en_q  <= PAR_EN;
      par_typ_q <= PAR_TYP;
    end
  end

  uart_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .data     (ser_p_data),
    .typ      (par_typ_q),
    .parity_c (parity_bit)
  );
`endif

  // Next-state and line/handshake outputs, all decoded from the current state.
  always_comb begin
    state_d = state_q;
    TX_OUT  = IDLE_LEVEL;
    BUSY    = 1'b1;
    ser_en  = 1'b0;
    case (state_q)
      IDLE: begin
        BUSY = 1'b0;
        if (DATA_VALID) state_d = START;
      end
      START: begin
        TX_OUT  = START_BIT;
        ser_en  = 1'b1;
        state_d = DATA;
      end
      DATA: begin
        TX_OUT = ser_data;
        ser_en = ~ser_done;
        if (ser_done) begin
`ifdef UART_TX_PARITY_EN
          state_d = par_en_q ? PARITY : STOP;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        TX_OUT  = parity_bit;
        state_d = STOP;
      end
`endif
      STOP: begin
        TX_OUT  = STOP_BIT;
        state_d = IDLE;
      end
      default: begin
        BUSY    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl with a behavioural serializer stub;
// parity vectors are added when UART_TX_PARITY_EN is defined.
module tb_uart_tx_ctrl;

  localparam int unsigned W = 8;

  logic         CLK = 1'b0;
  logic         RST;
  logic [W-1:0] P_DATA;
  logic         DATA_VALID;
  logic [W-1:0] ser_p_data;
  logic         ser_en;
  logic         ser_data;
  logic         ser_done;
  logic         TX_OUT;
  logic         BUSY;
`ifdef UART_TX_PARITY_EN
  logic         PAR_EN;
  logic         PAR_TYP;
`endif

  uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
`ifdef UART_TX_PARITY_EN
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
`endif
    .ser_p_data (ser_p_data),
    .ser_en     (ser_en),
    .ser_data   (ser_data),
    .ser_done   (ser_done),
    .TX_OUT     (TX_OUT),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  // Serializer stub: bit i shows up the cycle after the (i+1)-th ser_en.
  logic [3:0] sr_cnt;
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sr_cnt   <= '0;
      ser_data <= 1'b0;
      ser_done <= 1'b0;
    end else begin
      ser_done <= ser_en && (sr_cnt == 4'(W - 1));
      if (ser_en) begin
        ser_data <= ser_p_data[sr_cnt[2:0]];
        sr_cnt   <= sr_cnt + 4'd1;
      end else if (ser_done) begin
        sr_cnt <= '0;
      end
    end
  end

  typedef struct {
    logic [W-1:0] data;
    logic         pe;
    logic         pt;
    int           exp_len;
    logic         exp_par;
  } vec_t;

  vec_t tbl[$];
  logic exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one request at a negedge and score the whole frame; returns at the
  // first IDLE negedge after STOP with the observed line bits in 'seen'.
  task automatic send(input vec_t v, input bit keep, output logic [15:0] seen);
    int cyc;
    int busy_n;
    logic e;
    seen       = '0;
    P_DATA     = v.data;
    DATA_VALID = 1'b1;
`ifdef UART_TX_PARITY_EN
    PAR_EN  = v.pe;
    PAR_TYP = v.pt;
`endif
    exp_q.push_back(1'b0);
    for (int i = 0; i < int'(W); i++) exp_q.push_back(v.data[i]);
    if (v.pe) exp_q.push_back(v.exp_par);
    exp_q.push_back(1'b1);
    @(posedge CLK);
    @(negedge CLK);
    if (keep) P_DATA = '0;
    else DATA_VALID = 1'b0;
`ifdef UART_TX_PARITY_EN
    PAR_EN  = ~v.pe;
    PAR_TYP = ~v.pt;
`endif
    cyc    = 0;
    busy_n = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      seen[cyc] = TX_OUT;
      chk("tx_out", 32'(TX_OUT), 32'(e));
      chk("busy", 32'(BUSY), 32'd1);
      chk("ser_en", 32'(ser_en), 32'(cyc < int'(W)));
      chk("ser_p_data", 32'(ser_p_data), 32'(v.data));
      if (BUSY) busy_n++;
      cyc++;
      @(negedge CLK);
    end
    for (int g = 0; g < 4 && BUSY; g++) begin
      busy_n++;
      @(negedge CLK);
    end
    chk("frame_len", 32'(busy_n), 32'(v.exp_len));
    chk("idle_busy", 32'(BUSY), 32'd0);
    chk("idle_tx", 32'(TX_OUT), 32'd1);
    chk("idle_ser_en", 32'(ser_en), 32'd0);
    if (v.pe) chk("parity_bit", 32'(seen[W+1]), 32'(v.exp_par));
  endtask

  initial begin
    logic [15:0] seen;
    vec_t        v;

    tbl.push_back('{8'hA5, 1'b0, 1'b0, 10, 1'b0});
    tbl.push_back('{8'h3C, 1'b0, 1'b0, 10, 1'b0});
    tbl.push_back('{8'h01, 1'b0, 1'b0, 10, 1'b0});
    tbl.push_back('{8'h80, 1'b0, 1'b0, 10, 1'b0});
    tbl.push_back('{8'h00, 1'b0, 1'b0, 10, 1'b0});
`ifdef UART_TX_PARITY_EN
    tbl.push_back('{8'hA5, 1'b1, 1'b0, 11, 1'b0});
    tbl.push_back('{8'hA5, 1'b1, 1'b1, 11, 1'b1});
    tbl.push_back('{8'h07, 1'b1, 1'b0, 11, 1'b1});
    tbl.push_back('{8'h07, 1'b1, 1'b1, 11, 1'b0});
    PAR_EN  = 1'b0;
    PAR_TYP = 1'b0;
`endif

    RST        = 1'b0;
    P_DATA     = 8'h5A;
    DATA_VALID = 1'b1;
    #3;
    chk("rst_tx", 32'(TX_OUT), 32'd1);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_ser_en", 32'(ser_en), 32'd0);
    chk("rst_ser_p_data", 32'(ser_p_data), 32'd0);
    repeat (2) @(negedge CLK);
    chk("rst_hold_busy", 32'(BUSY), 32'd0);
    DATA_VALID = 1'b0;
    RST        = 1'b1;
    @(negedge CLK);
    chk("idle_tx_after_rst", 32'(TX_OUT), 32'd1);

    for (int k = 0; k < tbl.size(); k++) begin
      v = tbl[k];
      send(v, 1'b0, seen);
      if (k == 0) chk("a5_sequence", 32'(seen[9:0]), 32'(10'b1101001010));
      @(negedge CLK);
    end

    // Request held high across a frame with changing data.
    v = '{8'hFF, 1'b0, 1'b0, 10, 1'b0};
    send(v, 1'b1, seen);
    chk("ff_unchanged", 32'(seen[8:1]), 32'hFF);
    v = '{8'h00, 1'b0, 1'b0, 10, 1'b0};
    send(v, 1'b0, seen);

    // Asynchronous reset during DATA bit 3.
    P_DATA     = 8'hA5;
    DATA_VALID = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    DATA_VALID = 1'b0;
    repeat (4) @(negedge CLK);
    chk("pre_rst_bit3", 32'(TX_OUT), 32'd0);
    #2;
    RST = 1'b0;
    #1;
    chk("midrst_tx", 32'(TX_OUT), 32'd1);
    chk("midrst_busy", 32'(BUSY), 32'd0);
    chk("midrst_ser_en", 32'(ser_en), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("post_rst_tx", 32'(TX_OUT), 32'd1);
      chk("post_rst_busy", 32'(BUSY), 32'd0);
    end
    v = '{8'h96, 1'b0, 1'b0, 10, 1'b0};
    send(v, 1'b0, seen);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
